// File: rtl/rv32_pkg.sv
// rv32_pkg: shared opcodes, funct3 codes and FSM state for the RV32 MEM stage.
// Imported by rv32_mem_top and rv32_load_ext.
package rv32_pkg;

  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;

  localparam logic [2:0]  F3_LB  = 3'b000;
  localparam logic [2:0]  F3_LH  = 3'b001;
  localparam logic [2:0]  F3_LW  = 3'b010;
  localparam logic [2:0]  F3_LBU = 3'b100;
  localparam logic [2:0]  F3_LHU = 3'b101;

  localparam logic [2:0]  F3_SB  = 3'b000;
  localparam logic [2:0]  F3_SH  = 3'b001;
  localparam logic [2:0]  F3_SW  = 3'b010;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_e;

endpackage

// File: rtl/rv32_load_ext.sv
// rv32_load_ext: selects the byte/half lane of a read word and
// sign- or zero-extends it according to the load funct3.
module rv32_load_ext
  import rv32_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    unique case (addr)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    data = rdata;
    unique case (1'b1)
      funct3 == F3_LB:  data = {{24{b[7]}}, b};
      funct3 == F3_LBU: data = {24'd0, b};
      funct3 == F3_LH:  data = {{16{h[15]}}, h};
      funct3 == F3_LHU: data = {16'd0, h};
      default:          data = rdata;
    endcase
  end

endmodule

// File: rtl/rv32_mem_top.sv
// rv32_mem_top: RV32 memory-access stage driving a ready/valid data port.
// Define RV32_MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning down.
module rv32_mem_top
  import rv32_pkg::*;
#(
  parameter logic [31:0] NOP_IW = NOP_INSN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] rs2_data_in,
  input  logic [4:0]  wb_reg_in,
  input  logic        wb_enable_in,
  input  logic        wb_from_mem_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic [31:0] wb_data_out,
  output logic [4:0]  wb_reg_out,
  output logic        wb_enable_out,
  output logic        df_mem_enable,
  output logic [4:0]  df_mem_reg,
  output logic [31:0] df_mem_data,
  output logic        misalign_err
);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  a_q, a_d;
  logic [31:0] pcl_q, pcl_d;
  logic [31:0] iwl_q, iwl_d;
  logic [31:0] alul_q, alul_d;
  logic [4:0]  rdl_q, rdl_d;
  logic        enl_q, enl_d;
  logic [31:0] pco_q, pco_d;
  logic [31:0] iwo_q, iwo_d;
  logic [31:0] dato_q, dato_d;
  logic [4:0]  rdo_q, rdo_d;
  logic        eno_q, eno_d;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [1:0]  a;
  logic        is_load;
  logic        is_store;
  logic        mem_op;
  logic        sz_byte;
  logic        sz_half;
  logic        trap;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        unused_ok;

  assign opc      = iw_in[6:0];
  assign f3       = iw_in[14:12];
  assign a        = alu_in[1:0];
  assign is_load  = opc == OPC_LOAD;
  assign is_store = opc == OPC_STORE;
  assign mem_op   = is_load || is_store;
  // Anything that is not byte or half is a word access.
  assign sz_byte  = (f3 == F3_LB) || (is_load && f3 == F3_LBU);
  assign sz_half  = (f3 == F3_LH) || (is_load && f3 == F3_LHU);
  assign unused_ok = ^{iw_in[31:15], iw_in[11:7], wb_from_mem_in};

`ifdef RV32_MEM_MISALIGN_TRAP_EN
  logic err_q, err_d;

  assign trap = mem_op &&
                (sz_half ? a[0] : (!sz_byte && a != 2'b00));
  assign err_d = (state_q == S_IDLE) && trap;
  assign misalign_err = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`else
  assign trap = 1'b0;
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = rs2_data_in;
    unique case (1'b1)
      sz_byte: begin
        st_be    = 4'b0001 << a;
        st_wdata = {4{rs2_data_in[7:0]}};
      end
      sz_half: begin
        st_be    = a[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{rs2_data_in[15:0]}};
      end
      default: ;
    endcase
  end

  rv32_load_ext u_load_ext (
    .rdata  (dmem_rdata),
    .addr   (a_q),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    a_d       = a_q;
    pcl_d     = pcl_q;
    iwl_d     = iwl_q;
    alul_d    = alul_q;
    rdl_d     = rdl_q;
    enl_d     = enl_q;
    pco_d     = 32'd0;
    iwo_d     = NOP_IW;
    dato_d    = 32'd0;
    rdo_d     = 5'd0;
    eno_d     = 1'b0;
    stall_out = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_op && !trap) begin
          stall_out = 1'b1;
          state_d   = S_ACCESS;
          req_d     = 1'b1;
          we_d      = is_store;
          addr_d    = {alu_in[31:2], 2'b00};
          be_d      = st_be;
          wdata_d   = is_store ? st_wdata : 32'd0;
          f3_d      = f3;
          a_d       = a;
          pcl_d     = pc_in;
          iwl_d     = iw_in;
          alul_d    = alu_in;
          rdl_d     = wb_reg_in;
          enl_d     = wb_enable_in;
        end else if (!mem_op) begin
          pco_d  = pc_in;
          iwo_d  = iw_in;
          dato_d = alu_in;
          rdo_d  = wb_reg_in;
          eno_d  = wb_enable_in;
        end
      end
      S_ACCESS: begin
        if (dmem_ready) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          pco_d   = pcl_q;
          iwo_d   = iwl_q;
          dato_d  = we_q ? alul_q : ld_data;
          rdo_d   = rdl_q;
          eno_d   = enl_q;
        end else begin
          stall_out = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      a_q     <= 2'd0;
      pcl_q   <= 32'd0;
      iwl_q   <= 32'd0;
      alul_q  <= 32'd0;
      rdl_q   <= 5'd0;
      enl_q   <= 1'b0;
      pco_q   <= 32'd0;
      iwo_q   <= NOP_IW;
      dato_q  <= 32'd0;
      rdo_q   <= 5'd0;
      eno_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      pcl_q   <= pcl_d;
      iwl_q   <= iwl_d;
      alul_q  <= alul_d;
      rdl_q   <= rdl_d;
      enl_q   <= enl_d;
      pco_q   <= pco_d;
      iwo_q   <= iwo_d;
      dato_q  <= dato_d;
      rdo_q   <= rdo_d;
      eno_q   <= eno_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign pc_out        = pco_q;
  assign iw_out        = iwo_q;
  assign wb_data_out   = dato_q;
  assign wb_reg_out    = rdo_q;
  assign wb_enable_out = eno_q;
  assign df_mem_enable = eno_q;
  assign df_mem_reg    = rdo_q;
  assign df_mem_data   = dato_q;

endmodule
